data_arrays_0_init_ctrl: RTL and testbench

Front-end controller placed directly upstream of the D-Cache data RAM wrapper (`data_arrays_0_ext`, 1024 x 32, byte-masked). The sky130 SRAM macros power up with undefined contents, so after reset this block sweeps every word to a known value before passing D-Cache requests through to the RAM port. It also owns the one-cycle read-response timing, including a valid strobe and a held copy of the last read data. A software- or debug-triggered `init_req` re-runs the sweep.

---
 rtl/data_arrays_0_init_ctrl_if.sv | 25 ++
 rtl/data_arrays_0_init_ctrl.sv | 110 +++++++++++
 tb/tb_data_arrays_0_init_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_arrays_0_init_ctrl_if.sv
// rtl/data_arrays_0_init_ctrl_if.sv - D-Cache request/response bus between the cache and the RAM init controller
interface data_arrays_0_init_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wmode;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_addr, req_wmode, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wmode, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/data_arrays_0_init_ctrl.sv
// rtl/data_arrays_0_init_ctrl.sv - sweeps the D-Cache data RAM to a known value, then passes cache requests through
module data_arrays_0_init_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_req,
    output logic              init_busy,
    output logic              init_done,
    data_arrays_0_init_ctrl_if.slave req,
    output logic              RW0_clk,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wdata,
    output logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_rdata
);
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              rd_pend;
    logic [DATA_W-1:0] hold;
    logic              accept_rd;

    assign RW0_clk   = clock;
    assign accept_rd = (state == ST_RUN) && req.req_valid && !req.req_wmode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_START;
            cnt       <= '0;
            rd_pend   <= 1'b0;
            hold      <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            rd_pend   <= accept_rd;
            if (rd_pend) begin
                hold <= RW0_rdata;
            end
            case (state)
                ST_START: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
                ST_INIT: begin
                    // Last word detected by compare so the counter never relies on wrap.
                    if (cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_START;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Single mux onto the RAM port: the sweep owns it in INIT, the cache in RUN.
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wdata = '0;
        RW0_wmask = '0;
        case (state)
            ST_INIT: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt;
                RW0_wdata = INIT_VALUE;
                RW0_wmask = '1;
            end
            ST_RUN: begin
                RW0_en    = req.req_valid;
                RW0_wmode = req.req_wmode;
                RW0_addr  = req.req_addr;
                RW0_wdata = req.req_wdata;
                RW0_wmask = req.req_wmask;
            end
            default: begin
                RW0_en = 1'b0;
            end
        endcase
    end

    assign init_busy      = (state != ST_RUN);
    assign req.req_ready  = (state == ST_RUN);
    assign req.resp_valid = rd_pend;
    assign req.resp_data  = rd_pend ? RW0_rdata : hold;
endmodule

// File: tb/tb_data_arrays_0_init_ctrl.sv
// tb/tb_data_arrays_0_init_ctrl.sv - randomized self-checking bench for data_arrays_0_init_ctrl
module tb_data_arrays_0_init_ctrl;
    localparam int WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        init_req = 1'b0;
    logic        init_busy;
    logic        init_done;
    logic        RW0_clk;
    logic        RW0_en;
    logic        RW0_wmode;
    logic [9:0]  RW0_addr;
    logic [31:0] RW0_wdata;
    logic [3:0]  RW0_wmask;
    logic [31:0] RW0_rdata;

    int total = 0;
    int bad = 0;

    data_arrays_0_init_ctrl_if #(.ADDR_W(10), .DATA_W(32), .MASK_W(4)) bus ();

    data_arrays_0_init_ctrl #(
        .ADDR_W(10), .DATA_W(32), .MASK_W(4), .INIT_VALUE(32'h0)
    ) dut (
        .clock(clock), .reset(reset), .init_req(init_req),
        .init_busy(init_busy), .init_done(init_done), .req(bus),
        .RW0_clk(RW0_clk), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask),
        .RW0_rdata(RW0_rdata)
    );

    always #5 clock = ~clock;

    // RAM behind the controller: one-cycle read latency, byte-masked writes.
    logic [31:0] mem [WORDS];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int b = 0; b < 4; b++)
                    if (RW0_wmask[b]) mem[RW0_addr][8*b +: 8] <= RW0_wdata[8*b +: 8];
            end else begin
                RW0_rdata <= mem[RW0_addr];
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference model: m_idx = -1 before the sweep, 0..1023 = word being swept, 1024 = serving requests.
    logic [31:0] gold [WORDS];
    int          m_idx = -1;
    logic        m_rv = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hold = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_idx  <= -1;
            m_rv   <= 1'b0;
            m_done <= 1'b0;
            m_hold <= '0;
        end else begin
            m_rv   <= 1'b0;
            m_done <= 1'b0;
            if (m_idx == WORDS) begin
                if (bus.req_valid && bus.req_wmode)
                    gold[bus.req_addr] <= merge(gold[bus.req_addr], bus.req_wdata, bus.req_wmask);
                if (bus.req_valid && !bus.req_wmode) begin
                    m_rv   <= 1'b1;
                    m_hold <= gold[bus.req_addr];
                end
                if (init_req) m_idx <= 0;
            end else if (m_idx < 0) begin
                m_idx <= 0;
            end else begin
                gold[m_idx] <= 32'h0;
                m_idx       <= m_idx + 1;
                m_done      <= (m_idx == WORDS - 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("init_busy", init_busy, m_idx < WORDS);
            check("req_ready", bus.req_ready, m_idx == WORDS);
            check("init_done", init_done, m_done);
            check("resp_valid", bus.resp_valid, m_rv);
            check("resp_data", bus.resp_data, m_hold);
            if (m_idx >= 0 && m_idx < WORDS) begin
                check("sweep_en", {RW0_en, RW0_wmode, RW0_wmask}, 6'b11_1111);
                check("sweep_addr", RW0_addr, m_idx);
                check("sweep_wdata", RW0_wdata, 32'h0);
            end else if (m_idx == WORDS) begin
                check("run_en", RW0_en, bus.req_valid);
                if (bus.req_valid)
                    check("run_pass", {RW0_wmode, RW0_addr, RW0_wdata, RW0_wmask},
                          {bus.req_wmode, bus.req_addr, bus.req_wdata, bus.req_wmask});
            end else begin
                check("start_en", RW0_en, 1'b0);
            end
        end
    end

    task automatic cyc(input logic v, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic ir);
        bus.req_valid = v;
        bus.req_wmode = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        init_req      = ir;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            idle();
            n++;
        end while (!init_done && n < 2000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, init_busy, 1'b1);
        check({tag, "_ready"}, bus.req_ready, 1'b0);
        check({tag, "_rvalid"}, bus.resp_valid, 1'b0);
        check({tag, "_en"}, RW0_en, 1'b0);
        check({tag, "_done"}, init_done, 1'b0);
        check({tag, "_rdata"}, bus.resp_data, 32'h0);
    endtask

    initial begin
        int n;
        logic [9:0] a;
        bus.req_valid = 1'b0;
        bus.req_wmode = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;

        #12;
        check_reset_outputs("reset");
        @(posedge clock);
        #3 reset = 1'b0;
        wait_done(n);
        check("first_sweep_latency", n, 1025);
        check("first_run_ready", bus.req_ready, 1'b1);

        // Masked write then read-back.
        cyc(1'b1, 1'b1, 10'h155, 32'hDEADBEEF, 4'b0101, 1'b0);
        cyc(1'b1, 1'b0, 10'h155, 32'h0, 4'h0, 1'b0);
        check("masked_rvalid", bus.resp_valid, 1'b1);
        check("masked_rdata", bus.resp_data, 32'h00AD00EF);

        // Hold register on the last address.
        cyc(1'b1, 1'b1, 10'h3FF, 32'h12345678, 4'hF, 1'b0);
        cyc(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0);
        check("hold_rvalid", bus.resp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("hold_idle_rvalid", bus.resp_valid, 1'b0);
            check("hold_idle_rdata", bus.resp_data, 32'h12345678);
        end

        // Read accepted together with init_req, then a sweep under constant request pressure.
        cyc(1'b1, 1'b1, 10'h010, 32'hA5A5A5A5, 4'hF, 1'b0);
        cyc(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b1);
        check("simul_rvalid", bus.resp_valid, 1'b1);
        check("simul_rdata", bus.resp_data, 32'hA5A5A5A5);
        check("simul_busy", init_busy, 1'b1);
        n = 0;
        do begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            n++;
        end while (!init_done && n < 2000);
        check("resweep_latency", n, 1024);
        cyc(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
        check("resweep_rdata", bus.resp_data, 32'h0);

        // Randomized traffic on a small address window, with occasional re-init requests.
        for (int i = 0; i < 1500; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(1008, 1023));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 699) == 0));
        end
        wait_done(n);
        idle();

        // Asynchronous reset at sweep address 500.
        cyc(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);
        for (int i = 0; i < 500; i++) idle();
        check("pre_reset_addr", RW0_addr, 10'd500);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        wait_done(n);
        check("post_reset_latency", n, 1025);
        cyc(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0);
        check("post_reset_rdata", bus.resp_data, 32'h0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
